// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg : shared geometry, state encoding and bit-ordering helper for the
//           LED row transmitter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package led_pkg;

  localparam int NUM_BLK   = 40;
  localparam int BLK_W     = 8;
  localparam int ROW_W     = NUM_BLK * BLK_W;
  localparam int CNT_W     = $clog2(ROW_W);
  localparam int ROW_IDX_W = 6;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Reorders a row so that wire order equals transmit order: bit n of the
  // result is the n-th bit on led_sdi (byte 0 MSB first, then byte 1, ...).
  function automatic logic [ROW_W-1:0] stream_order(input logic [ROW_W-1:0] row);
    stream_order = '0;
    for (int n = 0; n < ROW_W; n++) begin
      stream_order[n] = row[(n / BLK_W) * BLK_W + (BLK_W - 1) - (n % BLK_W)];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_clk_div.sv
// ---------------------------------------------------------------------------
// led_clk_div : serial clock generator; CLK_DIV cycles per sclk half-period,
//               held low and cleared whenever disabled.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic rd_clk,
  input  logic rst_n,
  input  logic en,
  output logic tick,
  output logic sclk
);

  localparam logic [7:0] c_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       r_sclk;

  // tick marks the last cycle of the current half-period
  assign tick = en && (r_cnt == c_LAST);
  assign sclk = r_sclk;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (tick) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_row_tx.sv
// ---------------------------------------------------------------------------
// led_row_tx : captures completed brightness rows into a one-deep pending
//              buffer and serialises them to the LED driver chain.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_row_tx
  import led_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int LE_CYC  = 4
) (
  input  logic                 rd_clk,
  input  logic                 rst_n,
  input  logic                 empty,
  input  logic [ROW_W-1:0]     data0,
  input  logic [ROW_IDX_W-1:0] data_cnt,
  output logic                 led_sclk,
  output logic                 led_sdi,
  output logic                 led_le,
  output logic [ROW_IDX_W-1:0] led_row_sel,
  output logic                 busy,
  output logic                 row_done,
  output logic                 overrun
);

  localparam logic [CNT_W-1:0] c_BIT_LAST = CNT_W'(ROW_W - 1);
  localparam logic [7:0]       c_LE_LAST  = 8'(LE_CYC - 1);

  logic                 r_empty_d;
  logic                 r_strb;
  logic [ROW_W-1:0]     r_pend_data;
  logic [ROW_IDX_W-1:0] r_pend_row;
  logic                 r_pend_v;
  logic                 r_overrun;

  logic [2:0]           r_state;
  logic [ROW_W-1:0]     r_sr;
  logic [ROW_IDX_W-1:0] r_row;
  logic [ROW_IDX_W-1:0] r_row_sel;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [7:0]           r_le_cnt;

  logic                 w_rise;
  logic                 w_shift_en;
  logic                 w_tick;
  logic                 w_sclk;
  logic                 w_bit_end;

  assign w_rise     = empty & ~r_empty_d;
  assign w_shift_en = (r_state == ST_SHIFT);
  assign w_bit_end  = w_shift_en && w_tick && w_sclk;

  led_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .rd_clk (rd_clk),
    .rst_n  (rst_n),
    .en     (w_shift_en),
    .tick   (w_tick),
    .sclk   (w_sclk)
  );

  // Trigger and pending buffer; a new row arriving in LOAD replaces the one
  // being consumed, so it is not an overrun.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_empty_d   <= 1'b1;
      r_strb      <= 1'b0;
      r_pend_data <= '0;
      r_pend_row  <= '0;
      r_pend_v    <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_empty_d <= empty;
      r_strb    <= w_rise;
      if (r_strb) begin
        r_pend_data <= data0;
        r_pend_row  <= data_cnt;
        r_pend_v    <= 1'b1;
        if (r_pend_v && (r_state != ST_LOAD)) begin
          r_overrun <= 1'b1;
        end
      end else if (r_state == ST_LOAD) begin
        r_pend_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sr      <= '0;
      r_row     <= '0;
      r_row_sel <= '0;
      r_bit_cnt <= '0;
      r_le_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_pend_v) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_sr      <= stream_order(r_pend_data);
          r_row     <= r_pend_row;
          r_bit_cnt <= '0;
          r_state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // advance to the next bit as the high half-period ends
          if (w_bit_end) begin
            r_sr <= r_sr >> 1;
            if (r_bit_cnt == c_BIT_LAST) begin
              r_bit_cnt <= '0;
              r_le_cnt  <= '0;
              r_state   <= ST_LATCH;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        ST_LATCH: begin
          if (r_le_cnt == c_LE_LAST) begin
            r_le_cnt  <= '0;
            r_row_sel <= r_row;
            r_state   <= ST_DONE;
          end else begin
            r_le_cnt <= r_le_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign led_sclk    = w_sclk;
  assign led_sdi     = w_shift_en & r_sr[0];
  assign led_le      = (r_state == ST_LATCH);
  assign led_row_sel = r_row_sel;
  assign busy        = (r_state != ST_IDLE);
  assign row_done    = (r_state == ST_DONE);
  assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: doc/led_row_tx.md
Name: led_row_tx

Overview:
- Downstream stage of the FIFO-to-LED byte assembler in the local-dimming backlight path.
- Consumes the assembled 320-bit row of 40 block brightness bytes and the row index.
- Captures each completed row into a shadow register, then serialises it to the LED driver chain on a divided serial clock.
- Finishes each row with a latch pulse and a row-select update.

Parameters:
- NUM_BLK, 40, blocks per row (bytes per row vector).
- BLK_W, 8, bits per block brightness value.
- CLK_DIV, 2, rd_clk cycles per led_sclk half-period; legal range 1..255.
- LE_CYC, 4, rd_clk cycles led_le is held high; legal range 1..255.

Ports:
- rd_clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- empty  input  1  upstream FIFO empty flag; a 0->1 transition marks row completion.
- data0  input  NUM_BLK*BLK_W  assembled row; byte k occupies bits [8k+7:8k].
- data_cnt  input  6  row index for the row being completed.
- led_sclk  output  1  serial clock to the driver chain.
- led_sdi  output  1  serial data, MSB-first per byte.
- led_le  output  1  driver latch enable.
- led_row_sel  output  6  currently displayed row.
- busy  output  1  high while shifting or latching.
- row_done  output  1  one-cycle pulse when a row has been latched.
- overrun  output  1  sticky; set when a pending row is overwritten.

Behaviour:
- Clock and reset:
  - Single clock rd_clk; asynchronous active-low reset rst_n.
  - All outputs reset to 0.
  - Internal empty_d resets to 1, so no row is triggered at reset release.
  - Asserting rst_n mid-row aborts it immediately: outputs go to 0 and the pending row is discarded.
- Trigger:
  - rise = empty & ~empty_d, registered into strb.
  - In the cycle strb is high, data0 and data_cnt are final. They are sampled into the pending buffer (pend_data, pend_row) and pend_v is set.
- Pending buffer (one deep):
  - If pend_v is already set when strb fires, the buffer is overwritten and overrun is set.
  - overrun is cleared only by reset.
- State machine IDLE -> LOAD -> SHIFT -> LATCH -> DONE -> IDLE:
  - IDLE: if pend_v, go to LOAD.
  - LOAD (1 cycle): shift register <= pend_data, row register <= pend_row, clear pend_v. If strb fires in this same cycle, the new row goes into pend_v (set wins) with no overrun.
  - SHIFT: bit counter 0..NUM_BLK*BLK_W-1.
    - Bit order: byte 0 bits 7..0 first, then byte 1, and so on up to byte 39.
    - Each bit: led_sclk low for CLK_DIV cycles with led_sdi updated on the first of those cycles, then led_sclk high for CLK_DIV cycles.
    - led_sdi is stable across the whole high phase.
    - After the last high phase, go to LATCH with led_sclk=0.
  - LATCH: led_le=1 for LE_CYC cycles; led_sclk=0 and led_sdi=0.
  - DONE (1 cycle): led_le=0, led_row_sel <= row register, row_done=1, then IDLE. A set pend_v starts the next LOAD from IDLE one cycle later.
- busy is high in LOAD, SHIFT, LATCH and DONE.
- Latency: first led_sdi bit appears 3 cycles after the empty rise (strb, IDLE, LOAD).
- Row time: 3 + 2*CLK_DIV*NUM_BLK*BLK_W + LE_CYC + 1 cycles.
- Counters: bit counter sized clog2(NUM_BLK*BLK_W); divider counter 8 bits. Both wrap to 0 only on phase end, with no free-running wrap.
- data_cnt is passed through unmodified; a value of 0 is legal.

Decomposition:
- Shared package led_pkg: NUM_BLK, BLK_W, ROW_W = NUM_BLK*BLK_W, state enum {IDLE, LOAD, SHIFT, LATCH, DONE}.
- One natural sub-module: led_clk_div. Given CLK_DIV and an enable, it produces the phase-end tick and the sclk level. The FSM, shifter and pending buffer stay in led_row_tx.

Test Plan:
- Basic row, CLK_DIV=2, LE_CYC=4: data0 byte k = k+1, data_cnt=5, one empty 0->1 -> first sdi bit at +3 cycles, 320 sclk rising edges, sdi stream 0x01,0x02,...,0x28 MSB-first; led_le high exactly 4 cycles; row_done once; led_row_sel=5; row time 1288 cycles.
- Reset release with empty held 1 -> no trigger; busy stays 0; no sclk edges.
- Back-to-back rows: second empty rise arrives mid-SHIFT with data_cnt=6 -> row 6 shifts starting 2 cycles after the row_done of row 5; overrun stays 0.
- Overrun: three rises during one row with data_cnt=7, 8, 9 -> overrun=1; next row sent is 9, and row 8 is never output.
- Reset mid-SHIFT at bit 100 -> all outputs 0 within the reset; after release with empty=1, IDLE with no pending row.
- CLK_DIV=1, all-ones data0 -> sclk toggles every cycle, sdi constantly 1, led_le after exactly 640 shift cycles.
